// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the memory responder and the control unit's
// memory-wait logic. It holds the FSM state codes, the latched-operation
// encoding, the default geometry/latency constants and a request decode
// helper.
// -----------------------------------------------------------------------------
package mem_responder_pkg;

  // Defaults shared with the control unit so both sides agree on latency.
  localparam int MEM_DEPTH_DEFAULT       = 512;
  localparam int MEM_WAIT_CYCLES_DEFAULT = 2;

  // Responder FSM state codes (kept as plain constants for legacy users).
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // Operation latched at accept time.
  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_BAD   = 2'd2
  } op_e;

  // Classify a request. Only meaningful when rd or wr is high.
  // Both strobes high together is a protocol error.
  function automatic op_e decode_op(input logic rd, input logic wr);
    op_e op;
    if (rd && wr) begin
      op = OP_BAD;
    end else if (wr) begin
      op = OP_WRITE;
    end else begin
      op = OP_READ;
    end
    return op;
  endfunction

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port synchronous RAM with a write enable and a registered read port.
// The read register loads only on re_i. It is cleared on clr_i and otherwise
// holds its value. This lets the responder keep the last read word stable
// across writes and rejected requests.
// Ports:
//   clk      clock, rising edge
//   rst_n    async active-low reset (read register only)
//   we_i     write enable
//   re_i     read enable (loads the read register)
//   clr_i    clears the read register (ignored when re_i is high)
//   addr_i   word address, always in range when we_i/re_i are high
//   wdata_i  write data
//   rdata_o  registered read data
// -----------------------------------------------------------------------------
module mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter     INIT_FILE  = "",
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic                  clr_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array write port. Reset does not clear the contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read port. It holds its value unless a read or a clear occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= {DATA_WIDTH{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end else if (clr_i) begin
      rdata_q <= {DATA_WIDTH{1'b0}};
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the MAR/MDR interface. In IDLE it accepts a
// level-sensitive read or write and latches the address, data and operation.
// It then waits WAIT_CYCLES cycles, performs one array access and pulses done
// (plus err for a rejected request) for one cycle.
// Ports:
//   clk    clock, rising edge
//   reset  async active-low reset
//   read   read request (level)
//   write  write request (level)
//   addr   word address (MAR)
//   wdata  write data (MDR)
//   rdata  registered read data to Mdata_in
//   done   one-cycle completion pulse
//   busy   high whenever not IDLE
//   err    one-cycle error pulse, coincident with done
// -----------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = MEM_DEPTH_DEFAULT,
  parameter int WAIT_CYCLES = MEM_WAIT_CYCLES_DEFAULT,
  parameter     INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  op_e                   op_q, op_d;
  logic                  oor_q, oor_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic                  we_s;
  logic                  re_s;
  logic                  clr_s;

  // Next-state, latch and array-strobe logic for the request FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    oor_d   = oor_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_s    = 1'b0;
    re_s    = 1'b0;
    clr_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (read || write) begin
          op_d    = decode_op(read, write);
          // The upper address bits only take part in the range check.
          oor_d   = (addr >= 32'(DEPTH));
          addr_d  = addr[AW-1:0];
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CW'(WAIT_CYCLES);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        // Leaving on a count of 1 makes WAIT last exactly WAIT_CYCLES cycles.
        if (cnt_q == CW'(1)) begin
          state_d = ST_ACCESS;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end

      ST_ACCESS: begin
        state_d = ST_DONE;
        case (op_q)
          OP_READ: begin
            // An out-of-range read returns zero and does not touch the array.
            if (oor_q) begin
              clr_s = 1'b1;
            end else begin
              re_s  = 1'b1;
            end
          end
          OP_WRITE: begin
            if (oor_q) begin
              we_s = 1'b0;
            end else begin
              we_s = 1'b1;
            end
          end
          default: begin
            we_s = 1'b0;
          end
        endcase
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are decoded from the next state so they come out of flops.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    err_d  = done_d && ((op_d == OP_BAD) || oor_d);
  end

  // FSM, wait counter, request latches and status output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      op_q    <= OP_READ;
      oor_q   <= 1'b0;
      addr_q  <= {AW{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      oor_q   <= oor_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_FILE  (INIT_FILE),
    .AW         (AW)
  ) u_mem_array (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (we_s),
    .re_i    (re_s),
    .clr_i   (clr_s),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

  assign done = done_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule
